// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one outstanding load/store, programmable wait
// states, byte/halfword lane steering and load extension, stall toward the hazard logic.
module dmem_responder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned LATENCY   = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_funct3,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        mem_stall
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam bit ZERO_LAT = (LATENCY == 0);

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [ADDR_W+1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [2:0]          r_f3;
  logic [31:0]         r_rdata;
  logic                r_ready;
  logic                r_err;
  logic [31:0]         r_mem [2**ADDR_W];

  logic                w_idle;
  logic                w_access;
  logic                w_we;
  logic [ADDR_W+1:0]   w_addr;
  logic [ADDR_W-1:0]   w_idx;
  logic [31:0]         w_wdata;
  logic [2:0]          w_f3;
  logic                w_err;
  logic [31:0]         w_word;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load;
  logic [3:0]          w_be;
  logic [31:0]         w_sdata;
  logic                w_unused_addr;

  // Direct path in IDLE serves errors and zero-latency builds; WAIT uses the captured copy.
  assign w_idle        = (r_state == S_IDLE);
  assign w_we          = w_idle ? mem_we               : r_we;
  assign w_addr        = w_idle ? mem_addr[ADDR_W+1:0] : r_addr;
  assign w_wdata       = w_idle ? mem_wdata            : r_wdata;
  assign w_f3          = w_idle ? mem_funct3           : r_f3;
  assign w_idx         = w_addr[ADDR_W+1:2];
  assign w_word        = r_mem[w_idx];
  assign w_unused_addr = ^mem_addr[31:ADDR_W+2];

  always_comb begin
    case (w_f3)
      3'b000, 3'b100: w_err = 1'b0;
      3'b001, 3'b101: w_err = w_addr[0];
      3'b010:         w_err = |w_addr[1:0];
      default:        w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_next   = r_state;
    w_access = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_req) begin
          if (w_err || ZERO_LAT) begin
            w_next   = S_RESP;
            w_access = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_next   = S_RESP;
          w_access = 1'b1;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    case (w_addr[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];
    case (w_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'b0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'b0, w_half};
      default: w_load = w_word;
    endcase
  end

  always_comb begin
    case (w_f3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_addr[1:0];
        w_sdata = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
        w_sdata = {2{w_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_sdata = w_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && w_access && w_we && !w_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_sdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= w_access;
      r_err   <= w_access & w_err;
      r_rdata <= (w_access && !w_err && !w_we) ? w_load : '0;
      if (w_idle && mem_req) begin
        r_we    <= mem_we;
        r_addr  <= mem_addr[ADDR_W+1:0];
        r_wdata <= mem_wdata;
        r_f3    <= mem_funct3;
        r_cnt   <= 4'(LATENCY);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign mem_rdata = r_rdata;
  assign mem_ready = r_ready;
  assign mem_err   = r_err;
  assign mem_stall = mem_req & ~r_ready;

  a_req_held: assert property (@(posedge clk) disable iff (reset) (r_state == S_WAIT) |-> mem_req);

endmodule
